ram_host_arbiter: RTL and testbench

// Shares the single data/instr port of a fixed 1-cycle-latency SRAM between NrHosts

---
 rtl/ram_arb_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 56 +++++
 rtl/ram_host_arbiter.sv | 116 +++++++++++
 tb/tb_ram_host_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and host indices for the SRAM host arbiter.
package ram_arb_pkg;

  localparam int unsigned MaxHosts     = 4;
  localparam int unsigned HostIdxWidth = $clog2(MaxHosts);

  typedef logic [HostIdxWidth-1:0] host_idx_t;

  localparam host_idx_t HostInstr = host_idx_t'(0);
  localparam host_idx_t HostData  = host_idx_t'(1);
  localparam host_idx_t HostDma   = host_idx_t'(2);

  // Round-robin successor of idx among n hosts.
  function automatic host_idx_t next_idx(input host_idx_t idx, input int unsigned n);
    if (32'(idx) + 32'd1 >= n) begin
      return HostInstr;
    end
    return idx + host_idx_t'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, registered priority pointer.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NrHosts = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NrHosts-1:0] req,
  output logic [NrHosts-1:0] gnt_c,
  output host_idx_t          idx_c,
  output logic               valid_c
);

  host_idx_t ptr_q;
  host_idx_t ptr_d;

  // Grant the first requester at or after the pointer, wrapping modulo NrHosts.
  always_comb begin
    gnt_c   = '0;
    idx_c   = HostInstr;
    valid_c = 1'b0;
    for (int unsigned i = 0; i < NrHosts; i++) begin
      int unsigned cand;
      cand = 32'(ptr_q) + i;
      if (cand >= NrHosts) begin
        cand = cand - NrHosts;
      end
      for (int unsigned j = 0; j < NrHosts; j++) begin
        if (!valid_c && req[j] && (cand == j)) begin
          valid_c  = 1'b1;
          gnt_c[j] = 1'b1;
          idx_c    = host_idx_t'(j);
        end
      end
    end
  end

  // Pointer moves past the granted host; holds when nobody is granted.
  always_comb begin
    ptr_d = ptr_q;
    if (valid_c) begin
      ptr_d = next_idx(idx_c, NrHosts);
    end
  end

  // Pointer register; host 0 has top priority out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= HostInstr;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ram_host_arbiter.sv
// Shares one 1-cycle-latency SRAM port among NrHosts requesters, routing
// responses back to the issuing host and rejecting out-of-window accesses.
module ram_host_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned          NrHosts   = 2,
  parameter int unsigned          AddrWidth = 32,
  parameter int unsigned          DataWidth = 32,
  parameter logic [AddrWidth-1:0] RamBase   = 32'h0010_0000,
  parameter logic [AddrWidth-1:0] RamMask   = ~32'h000F_FFFF
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NrHosts-1:0]                   host_req_i,
  output logic [NrHosts-1:0]                   host_gnt_o,
  input  logic [NrHosts-1:0][AddrWidth-1:0]    host_addr_i,
  input  logic [NrHosts-1:0]                   host_we_i,
  input  logic [NrHosts-1:0][DataWidth/8-1:0]  host_be_i,
  input  logic [NrHosts-1:0][DataWidth-1:0]    host_wdata_i,
  output logic [NrHosts-1:0]                   host_rvalid_o,
  output logic [NrHosts-1:0][DataWidth-1:0]    host_rdata_o,
  output logic [NrHosts-1:0]                   host_err_o,
  output logic                                 ram_req_o,
  output logic [AddrWidth-1:0]                 ram_addr_o,
  output logic                                 ram_we_o,
  output logic [DataWidth/8-1:0]               ram_be_o,
  output logic [DataWidth-1:0]                 ram_wdata_o,
  input  logic                                 ram_rvalid_i,
  input  logic [DataWidth-1:0]                 ram_rdata_i
);

  localparam int unsigned BeWidth = DataWidth / 8;

  logic [NrHosts-1:0]   arb_gnt;
  host_idx_t            arb_idx;
  logic                 arb_valid;
  logic [AddrWidth-1:0] sel_addr;
  logic                 sel_we;
  logic [BeWidth-1:0]   sel_be;
  logic [DataWidth-1:0] sel_wdata;
  logic                 hit;
  logic                 resp_valid_q;
  logic                 resp_err_q;
  host_idx_t            resp_id_q;

  rr_arbiter #(
    .NrHosts (NrHosts)
  ) u_rr_arbiter (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .req     (host_req_i),
    .gnt_c   (arb_gnt),
    .idx_c   (arb_idx),
    .valid_c (arb_valid)
  );

  assign host_gnt_o = arb_gnt;

  // Select the granted host's request fields (one-hot mux).
  always_comb begin
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_be    = '0;
    sel_wdata = '0;
    for (int unsigned j = 0; j < NrHosts; j++) begin
      if (arb_gnt[j]) begin
        sel_addr  = host_addr_i[j];
        sel_we    = host_we_i[j];
        sel_be    = host_be_i[j];
        sel_wdata = host_wdata_i[j];
      end
    end
  end

  // Window decode; misses never reach the SRAM, so a miss write cannot land.
  always_comb begin
    hit         = ((sel_addr & RamMask) == RamBase);
    ram_req_o   = arb_valid & hit;
    ram_addr_o  = sel_addr;
    ram_we_o    = arb_valid & hit & sel_we;
    ram_be_o    = sel_be;
    ram_wdata_o = sel_wdata;
  end

  // Response register: one entry, since the SRAM answers exactly one cycle later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_id_q    <= HostInstr;
    end else begin
      resp_valid_q <= arb_valid;
      resp_err_q   <= arb_valid & ~hit;
      if (arb_valid) begin
        resp_id_q <= arb_idx;
      end
    end
  end

  // Route the response to the issuing host; read data is broadcast, zeroed on error.
  always_comb begin
    host_rvalid_o = '0;
    host_err_o    = '0;
    host_rdata_o  = '0;
    for (int unsigned j = 0; j < NrHosts; j++) begin
      host_rvalid_o[j] = resp_valid_q && (resp_id_q == host_idx_t'(j));
      host_err_o[j]    = resp_valid_q && (resp_id_q == host_idx_t'(j)) && resp_err_q;
      host_rdata_o[j]  = resp_err_q ? '0 : ram_rdata_i;
    end
  end

  // The SRAM must answer exactly the accesses forwarded one cycle earlier.
  ram_rsp_check: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ram_rvalid_i == (resp_valid_q && !resp_err_q));

endmodule

// File: tb/tb_ram_host_arbiter.sv
// Bench for ram_host_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_ram_host_arbiter;
  import ram_arb_pkg::*;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic                  clk = 1'b0;
  logic                  rst_ni;
  logic [N-1:0]          host_req_i, host_gnt_o, host_we_i, host_rvalid_o, host_err_o;
  logic [N-1:0][AW-1:0]  host_addr_i;
  logic [N-1:0][BW-1:0]  host_be_i;
  logic [N-1:0][DW-1:0]  host_wdata_i, host_rdata_o;
  logic                  ram_req_o, ram_we_o, ram_rvalid_i;
  logic [AW-1:0]         ram_addr_o;
  logic [BW-1:0]         ram_be_o;
  logic [DW-1:0]         ram_wdata_o, ram_rdata_i;

  int checks = 0;
  int errors = 0;

  ram_host_arbiter #(.NrHosts(N), .AddrWidth(AW), .DataWidth(DW)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .host_req_i(host_req_i), .host_gnt_o(host_gnt_o), .host_addr_i(host_addr_i),
    .host_we_i(host_we_i), .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
    .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
    .ram_req_o(ram_req_o), .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o),
    .ram_be_o(ram_be_o), .ram_wdata_o(ram_wdata_o),
    .ram_rvalid_i(ram_rvalid_i), .ram_rdata_i(ram_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    if (i == 4)  return 32'hDEAD_BEEF;
    if (i == 60) return 32'h1122_3344;
    return 32'hA5A5_0000 ^ (32'(i) * 32'h0001_0003);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // SRAM model: fixed one-cycle latency, 64 words covering the test addresses.
  logic [31:0] sram [64];
  bit          sram_init_done;
  int          sram_writes = 0;
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      ram_rvalid_i <= 1'b0;
      ram_rdata_i  <= '0;
      if (!sram_init_done) begin
        for (int i = 0; i < 64; i++) sram[i] <= init_word(i);
        sram_init_done <= 1'b1;
      end
    end else begin
      ram_rvalid_i <= ram_req_o;
      ram_rdata_i  <= $urandom;
      if (ram_req_o && ram_we_o) begin
        sram[ram_addr_o[7:2]] <= merge(sram[ram_addr_o[7:2]], ram_wdata_o, ram_be_o);
        sram_writes <= sram_writes + 1;
      end else if (ram_req_o) begin
        ram_rdata_i <= sram[ram_addr_o[7:2]];
      end
    end
  end

  // Reference model: per-cycle grant from rr order, one pending response, own memory image.
  logic [31:0]  ref_mem [64];
  bit           ref_init_done;
  int           m_ptr;
  bit           pend_v, pend_err, pend_we;
  int           pend_id;
  logic [31:0]  pend_data;
  int           waitc [N];
  logic [N-1:0] granted_last;

  always @(negedge clk) begin
    int          eg;
    logic [N-1:0] exp_gnt;
    logic [31:0] a;
    bit          hitm, exp_rv;
    if (!rst_ni) begin
      if (!ref_init_done) begin
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        ref_init_done = 1'b1;
      end
      m_ptr = 0; pend_v = 1'b0; granted_last = '0;
      for (int h = 0; h < N; h++) waitc[h] = 0;
      chk("reset_quiet", {host_rvalid_o, host_err_o}, '0);
    end else begin
      for (int h = 0; h < N; h++) begin
        exp_rv = pend_v && (pend_id == h);
        chk($sformatf("rvalid%0d", h), host_rvalid_o[h], exp_rv);
        chk($sformatf("err%0d", h), host_err_o[h], exp_rv && pend_err);
        if (exp_rv && pend_err) chk($sformatf("rdata_err%0d", h), host_rdata_o[h], 0);
        else if (exp_rv && !pend_we) chk($sformatf("rdata%0d", h), host_rdata_o[h], pend_data);
      end
      chk("ram_rvalid", ram_rvalid_i, pend_v && !pend_err);
      eg = -1;
      for (int i = 0; i < N; i++) begin
        int c;
        c = (m_ptr + i) % N;
        if (eg < 0 && host_req_i[c]) eg = c;
      end
      exp_gnt = '0;
      if (eg >= 0) exp_gnt[eg] = 1'b1;
      chk("gnt", host_gnt_o, exp_gnt);
      hitm = 1'b0;
      a = '0;
      if (eg >= 0) begin
        a = host_addr_i[eg];
        hitm = (a[31:20] == 12'h001);
        chk("ram_req", ram_req_o, hitm);
        if (hitm) chk("ram_fields", {ram_addr_o, ram_we_o, ram_be_o, 27'(ram_wdata_o)},
                      {a, host_we_i[eg], host_be_i[eg], 27'(host_wdata_i[eg])});
        else      chk("miss_no_write", ram_we_o, 1'b0);
      end else begin
        chk("ram_req_idle", ram_req_o, 1'b0);
      end
      for (int h = 0; h < N; h++) begin
        if (host_req_i[h] && !exp_gnt[h]) waitc[h]++;
        else waitc[h] = 0;
        if (host_req_i[h]) chk($sformatf("starve%0d", h), waitc[h] < N, 1'b1);
      end
      pend_v = (eg >= 0);
      if (eg >= 0) begin
        pend_id  = eg;
        pend_err = !hitm;
        pend_we  = host_we_i[eg];
        if (hitm && host_we_i[eg]) ref_mem[a[7:2]] = merge(ref_mem[a[7:2]], host_wdata_i[eg], host_be_i[eg]);
        else if (hitm) pend_data = ref_mem[a[7:2]];
        m_ptr = (eg + 1) % N;
      end
      granted_last = exp_gnt;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_host(input int h, input bit req, input logic [31:0] addr, input bit we,
                          input logic [3:0] be, input logic [31:0] wd);
    host_req_i[h] = req; host_addr_i[h] = addr; host_we_i[h] = we;
    host_be_i[h] = be; host_wdata_i[h] = wd;
  endtask

  task automatic new_req(input int h);
    logic [31:0] addr;
    if ($urandom_range(0, 7) == 0) addr = {12'($urandom_range(2, 4095)), 20'($urandom)} & ~32'h3;
    else addr = 32'h0010_0000 | (32'($urandom_range(0, 63)) << 2);
    set_host(h, 1'b1, addr, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
  endtask

  initial begin
    int h0, h1, h2, w0;
    h0 = int'(HostInstr); h1 = int'(HostData); h2 = int'(HostDma);
    rst_ni = 1'b0;
    host_req_i = '0; host_addr_i = '0; host_we_i = '0; host_be_i = '0; host_wdata_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;

    // Idle after reset.
    @(negedge clk);
    chk("t1_idle", {host_gnt_o, host_rvalid_o, host_err_o, ram_req_o}, '0);

    // Single read by the instruction host.
    tick(); set_host(h0, 1, 32'h0010_0010, 0, 4'hF, 0);
    @(negedge clk); chk("t2_gnt", {host_gnt_o, ram_req_o}, {3'b001, 1'b1});
    tick(); host_req_i = '0;
    @(negedge clk); chk("t2_rvalid", {host_rvalid_o, host_err_o}, {3'b001, 3'b000});
    chk("t2_rdata", host_rdata_o[h0], 32'hDEAD_BEEF);

    // Out-of-window write is rejected locally.
    tick(); set_host(h1, 1, 32'h0002_0000, 1, 4'hF, 32'h1234); w0 = sram_writes;
    @(negedge clk); chk("t4_gnt", {host_gnt_o, ram_req_o}, {3'b010, 1'b0});
    tick(); host_req_i = '0;
    @(negedge clk); chk("t4_resp", {host_rvalid_o, host_err_o}, {3'b010, 3'b010});
    chk("t4_rdata", host_rdata_o[h1], 0);
    chk("t4_sram", sram_writes, w0);

    // Two hosts holding requests alternate.
    tick(); set_host(h0, 1, 32'h0010_0000, 0, 4'hF, 0); set_host(h1, 1, 32'h0010_0004, 0, 4'hF, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("t3_gnt%0d", i), host_gnt_o, (i % 2 == 0) ? 3'b001 : 3'b010);
      if (i > 0) chk($sformatf("t3_rv%0d", i), host_rvalid_o, (i % 2 == 1) ? 3'b001 : 3'b010);
      tick();
      if (i == 5) host_req_i = '0;
    end
    @(negedge clk); chk("t3_rv_last", host_rvalid_o, 3'b010);

    // Partial write then back-to-back read of the same word.
    tick(); set_host(h1, 1, 32'h0010_00F0, 1, 4'b0011, 32'hAABB_CCDD);
    @(negedge clk); chk("t5_wgnt", host_gnt_o, 3'b010);
    tick(); host_req_i = '0; set_host(h0, 1, 32'h0010_00F0, 0, 4'hF, 0);
    @(negedge clk); chk("t5_rgnt", host_gnt_o, 3'b001);
    tick(); host_req_i = '0;
    @(negedge clk); chk("t5_rdata", host_rdata_o[h0], 32'h1122_CCDD);
    chk("t5_rvalid", host_rvalid_o, 3'b001);

    // Reset in the cycle after a DMA grant drops its response.
    tick(); set_host(h2, 1, 32'h0010_0020, 0, 4'hF, 0);
    @(negedge clk); chk("t6_gnt2", host_gnt_o, 3'b100);
    tick(); host_req_i = '0; rst_ni = 1'b0;
    set_host(h0, 1, 32'h0010_0008, 0, 4'hF, 0); set_host(h1, 1, 32'h0010_000C, 0, 4'hF, 0);
    @(negedge clk); chk("t6_drop", host_rvalid_o, 3'b000);
    tick(); tick(); rst_ni = 1'b1;
    @(negedge clk); chk("t6_first", host_gnt_o, 3'b001);
    tick(); host_req_i = '0;
    @(negedge clk); chk("t6_rv", host_rvalid_o, 3'b001);

    // Randomized traffic with occasional mid-operation resets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if ($urandom_range(0, 399) == 0) begin
        rst_ni = 1'b0; host_req_i = '0;
        tick(); rst_ni = 1'b1;
        continue;
      end
      for (int h = 0; h < N; h++) begin
        if (host_req_i[h] && granted_last[h]) host_req_i[h] = 1'b0;
        if (!host_req_i[h] && $urandom_range(0, 9) < 6) new_req(h);
      end
    end
    tick(); host_req_i = '0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
